// File: rtl/dec_scan_sequencer.sv
// Round-robin channel scanner driving the select pair of a downstream 2-to-4 decoder.
// Dwells DIV cycles per enabled channel, skips masked channels, and pulses wrap once per full scan.
module dec_scan_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] mask,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_sel;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic            r_wrap;

  logic [1:0]      w_lowest;
  logic [1:0]      w_next;
  logic            w_mask_any;
  logic            w_dwell_end;

  // Lowest set bit index; callers guarantee m is non-zero.
  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) begin
        res = 2'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next enabled channel searching cur+1 .. cur+4; the nearest hit wins, cur+4 == cur.
  function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] res;
    logic [1:0] idx;
    res = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_mask_any  = (mask != 4'b0000);
  assign w_lowest    = f_lowest(mask);
  assign w_next      = f_next(r_sel, mask);
  assign w_dwell_end = (r_cnt == CW'(DIV - 1));

  // Scan FSM: state, select, dwell counter and the registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wrap <= 1'b0;
          r_cnt  <= '0;
          if (en && w_mask_any) begin
            r_state <= SCAN;
            r_sel   <= w_lowest;
            r_valid <= 1'b1;
          end else begin
            r_valid <= 1'b0;
          end
        end
        SCAN: begin
          // Stopping outranks advancing, so a coincident dwell end never wraps.
          if (!en || !w_mask_any) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
          end else if (!w_dwell_end) begin
            r_cnt  <= r_cnt + CW'(1);
            r_wrap <= 1'b0;
          end else begin
            r_cnt  <= '0;
            r_sel  <= w_next;
            r_wrap <= (w_next <= r_sel);
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 2'd0;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign a     = r_sel[1];
  assign b     = r_sel[0];
  assign valid = r_valid;
  assign wrap  = r_wrap;

endmodule
